// File: rtl/alu_seq_exec.sv
// Sequential execute-stage ALU: single-cycle logic/arithmetic ops and
// bit-serial shifts, with a valid/ready handshake on both sides.
`timescale 1ns/1ps
module alu_seq_exec #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero
);

  localparam int unsigned DW = DATA_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;
  typedef enum logic [1:0] {SH_SRL, SH_SLL, SH_SRA} shift_e;

  state_e              state_q;
  shift_e              sh_op_q;
  shift_e              sh_op_c;
  logic [SHAMT_W-1:0]  count_q;
  logic [DW-1:0]       sh_q;
  logic [DW-1:0]       result_q;
  logic                zero_q;
  logic                in_ready_q;
  logic                out_valid_q;

  logic [SHAMT_W-1:0]  shamt_c;
  logic                is_shift_c;
  logic [DW-1:0]       alu_c;
  logic [DW-1:0]       sh_step_c;

  assign shamt_c = SrcB[SHAMT_W-1:0];

  // Single-cycle result; shifts only reach here with a zero shift amount.
  always_comb begin
    alu_c      = '0;
    is_shift_c = 1'b0;
    sh_op_c    = SH_SRL;
    case (Operation)
      4'b0000: alu_c = SrcA & SrcB;
      4'b0001: alu_c = SrcA | SrcB;
      4'b0010: alu_c = SrcA + SrcB;
      4'b0011: alu_c = SrcA - SrcB;
      4'b0100: alu_c = SrcA ^ SrcB;
      4'b0101: begin alu_c = SrcA; is_shift_c = 1'b1; sh_op_c = SH_SRL; end
      4'b0110: begin alu_c = SrcA; is_shift_c = 1'b1; sh_op_c = SH_SLL; end
      4'b0111: begin alu_c = SrcA; is_shift_c = 1'b1; sh_op_c = SH_SRA; end
      4'b1000: alu_c = DW'(SrcA == SrcB);
      4'b1010: alu_c = SrcB;
      4'b1100,
      4'b1110: alu_c = DW'($signed(SrcA) < $signed(SrcB));
      default: alu_c = '0;
    endcase
  end

  // One-bit shift step of the iterating shift register.
  always_comb begin
    sh_step_c = sh_q;
    case (sh_op_q)
      SH_SRL:  sh_step_c = {1'b0, sh_q[DW-1:1]};
      SH_SLL:  sh_step_c = {sh_q[DW-2:0], 1'b0};
      SH_SRA:  sh_step_c = {sh_q[DW-1], sh_q[DW-1:1]};
      default: sh_step_c = sh_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sh_op_q     <= SH_SRL;
      count_q     <= '0;
      sh_q        <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (is_shift_c && (shamt_c != '0)) begin
              sh_q    <= SrcA;
              sh_op_q <= sh_op_c;
              count_q <= shamt_c;
              state_q <= ST_SHIFT;
            end else begin
              result_q    <= alu_c;
              zero_q      <= (alu_c == '0);
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          sh_q    <= sh_step_c;
          count_q <= count_q - SHAMT_W'(1);
          if (count_q == SHAMT_W'(1)) begin
            result_q    <= sh_step_c;
            zero_q      <= (sh_step_c == '0);
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign ALUResult = result_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Scoreboard bench for alu_seq_exec: directed vectors with hand-computed
// results; a negedge monitor checks value, Zero, latency and stability.
`timescale 1ns/1ps
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  Operation = 4'b0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] ALUResult;
  logic        Zero;

  alu_seq_exec #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .Zero(Zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    int          vcyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   errs = 0;
  int   hs_edge = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every cycle a result is presented, pops on handshake.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      chk("in_ready_low_while_valid", 32'(in_ready), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        if (!prev_valid) chk("latency", 32'(cyc), 32'(sb[0].vcyc));
        chk("ALUResult", ALUResult, sb[0].res);
        chk("Zero", 32'(Zero), 32'(sb[0].zero));
        if (out_ready) begin
          void'(sb.pop_front());
          hs_edge = cyc + 1;
        end
      end
    end
    prev_valid = out_valid & ~reset;
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input int s, output int acc);
    exp_t e;
    int   n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; Operation = op; SrcA = a; SrcB = b;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    acc    = cyc;
    e.res  = r;
    e.zero = (r == 32'd0);
    e.vcyc = acc + s;
    sb.push_back(e);
    in_valid = 1'b0; Operation = ~op; SrcA = ~a; SrcB = ~b;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    chk("in_ready_after_handshake", 32'(in_ready), 32'd1);
  endtask

  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input int s);
    int acc;
    issue(op, a, b, r, s, acc);
    drain();
  endtask

  initial begin
    int acc1;
    int acc2;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ALUResult", ALUResult, 32'd0);
    chk("rst_Zero", 32'(Zero), 32'd1);

    run(4'b0010, 32'd5, 32'd7, 32'd12, 0);
    run(4'b0011, 32'd3, 32'd5, 32'hFFFF_FFFE, 0);
    run(4'b0011, 32'h1234, 32'h1234, 32'd0, 0);
    run(4'b1100, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
    run(4'b1110, 32'd5, 32'd3, 32'd0, 0);
    run(4'b1000, 32'h9, 32'h9, 32'd1, 0);
    run(4'b1000, 32'h9, 32'h8, 32'd0, 0);
    run(4'b0000, 32'hF0, 32'h0F, 32'd0, 0);
    run(4'b0001, 32'hF0, 32'h0F, 32'hFF, 0);
    run(4'b1010, 32'd0, 32'hABCD_0000, 32'hABCD_0000, 0);
    run(4'b1111, 32'h55, 32'h66, 32'd0, 0);
    run(4'b0111, 32'h8000_0000, 32'h3F, 32'hFFFF_FFFF, 31);
    run(4'b0101, 32'h8000_0000, 32'h3F, 32'h0000_0001, 31);
    run(4'b0110, 32'h1, 32'h20, 32'h1, 0);
    run(4'b0110, 32'h3, 32'h4, 32'h30, 4);
    run(4'b0111, 32'h4000_0000, 32'h2, 32'h1000_0000, 2);

    // Backpressure with a second request waiting
    out_ready = 1'b0;
    issue(4'b0100, 32'hF0F0, 32'h0FF0, 32'hFF00, 0, acc1);
    fork
      issue(4'b0010, 32'd1, 32'd1, 32'd2, 0, acc2);
      begin
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    chk("second_accept_cycle", 32'(acc2), 32'(hs_edge + 1));
    drain();

    // Reset in the middle of a long shift
    issue(4'b0110, 32'h1, 32'd20, 32'h0010_0000, 20, acc1);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_ALUResult", ALUResult, 32'd0);
    chk("abort_Zero", 32'(Zero), 32'd1);
    run(4'b0010, 32'h10, 32'h20, 32'h30, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
